dreg_share_arbiter: RTL and testbench

- Shares one DATA_W-bit D-flip-flop data register among NUM_REQ requesters.
- Each requester presents a byte with a request. The block grants one requester at a time in round-robin order and captures that requester's data into the shared register.
- The captured data is held on the output with a valid/ready handshake until the consumer accepts it.
- Sits between multiple stimulus/producer agents and a single 8-bit register stage. It replaces ad-hoc per-requester drive of the register input.

---
 rtl/dreg_share_arbiter.sv | 118 +++++++++++
 tb/tb_dreg_share_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dreg_share_arbiter.sv
// Round-robin arbiter that shares one data register among NUM_REQ requesters.
// Each capture is held with a valid/ready handshake for at least HOLD_CYCLES cycles.
module dreg_share_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [DATA_W-1:0]          data_out,
    output logic                       out_valid,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    input  logic                       out_ready
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SRC_W-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [DATA_W-1:0]   data_d;
    logic                valid_d;
    logic [SRC_W-1:0]    src_d;

    logic                found;
    logic [SRC_W-1:0]    win;
    logic [SRC_W-1:0]    idx;
    logic                hold_done;

    assign hold_done = (cnt_q == HOLD_MAX) && out_ready;

    // First set request strictly after last_q, wrapping modulo NUM_REQ.
    always_comb begin : rr_pick
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = SRC_W'((int'(last_q) + k) % int'(NUM_REQ));
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= LAST_INIT;
            gnt       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt       <= gnt_d;
            data_out  <= data_d;
            out_valid <= valid_d;
            out_src   <= src_d;
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = HOLD;
            HOLD:    if (hold_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and output registers.
    always_comb begin : next_outputs
        gnt_d   = '0;
        data_d  = data_out;
        valid_d = out_valid;
        src_d   = out_src;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = NUM_REQ'(1) << win;
                    data_d  = req_data[int'(win)*int'(DATA_W) +: DATA_W];
                    src_d   = win;
                    valid_d = 1'b1;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q != HOLD_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (hold_done) valid_d = 1'b0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dreg_share_arbiter.sv
// Bench for dreg_share_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_dreg_share_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned HC = 2;
    localparam int unsigned SW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic [DW-1:0]     data_out;
    logic              out_valid;
    logic [SW-1:0]     out_src;
    logic              out_ready;

    dreg_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(HC)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .data_out(data_out), .out_valid(out_valid),
        .out_src(out_src), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit            m_busy;
    int            m_age;
    int            m_last;
    int            m_src;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [NR-1:0] m_gnt;

    logic [NR-1:0] persist;
    bit            rand_mode;
    int            cyc;
    int            vcnt;
    int            cap_log[$];
    int            cap_cyc[$];
    int            wait_cnt[NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_age   = 0;
        m_last  = NR - 1;
        m_src   = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_gnt   = '0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    endfunction

    function automatic logic [DW-1:0] get_data(input int i);
        return req_data[i*DW +: DW];
    endfunction

    // One clock: advance model on the edge, compare 1 time unit later, then react as requesters.
    task automatic cycle();
        int w;
        @(posedge clock);
        cyc++;
        m_gnt = '0;
        if (!m_busy) begin
            if (req != '0) begin
                w = -1;
                for (int k = 1; k <= NR; k++) begin
                    if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
                end
                m_data  = get_data(w);
                m_src   = w;
                m_gnt   = NR'(1) << w;
                m_valid = 1'b1;
                m_last  = w;
                m_age   = 0;
                m_busy  = 1'b1;
                cap_log.push_back(w);
                cap_cyc.push_back(cyc);
                chk("rr_wait_bound", 32'(wait_cnt[w] <= NR - 1), 32'd1);
                for (int i = 0; i < NR; i++) begin
                    if (i == w || !req[i]) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                end
            end
        end else begin
            if (m_age >= HC - 1) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end
            end else begin
                m_age++;
            end
        end
        #1;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_src", 32'(out_src), 32'(m_src));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (out_valid) vcnt++;
        for (int i = 0; i < NR; i++) begin
            if (m_gnt[i]) begin
                if (persist[i]) req_data[i*DW +: DW] = DW'($urandom);
                else req[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 99) < 30) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < 60);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
        chk({tag, "_src"}, 32'(out_src), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("rst");
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        req_data  = '0;
        out_ready = 1'b1;
        persist   = '0;
        rand_mode = 1'b0;
        cyc       = 0;
        vcnt      = 0;
        model_reset();
        #12;
        check_zero("por");
        @(negedge clock);
        reset = 1'b1;

        // Idle: nothing requested
        repeat (10) cycle();

        // Single request
        cap_log.delete();
        vcnt = 0;
        req = 4'b0001;
        req_data[0 +: DW] = 8'hA5;
        repeat (6) cycle();
        chk("single_caps", 32'(cap_log.size()), 32'd1);
        chk("single_data", 32'(data_out), 32'hA5);
        chk("single_vcnt", 32'(vcnt), 32'd2);

        // All four requesting: captured 0..3, three cycles apart
        do_reset();
        cap_log.delete();
        cap_cyc.delete();
        req = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
        repeat (14) cycle();
        chk("rr4_caps", 32'(cap_log.size()), 32'd4);
        for (int i = 0; i < cap_log.size(); i++) chk("rr4_order", 32'(cap_log[i]), 32'(i));
        for (int i = 1; i < cap_cyc.size(); i++) chk("rr4_spacing", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd3);

        // Persistent requesters 1 and 3 alternate
        cap_log.delete();
        persist = 4'b1010;
        req = 4'b1010;
        repeat (15) cycle();
        chk("alt_caps", 32'(cap_log.size() >= 4), 32'd1);
        for (int i = 0; i < cap_log.size(); i++) chk("alt_order", 32'(cap_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
        persist = '0;
        req = '0;
        repeat (4) cycle();

        // Backpressure: hold 8'h3C through a 7-cycle stall
        out_ready = 1'b0;
        req = 4'b0001;
        req_data[0 +: DW] = 8'h3C;
        cycle();
        chk("bp_gnt", 32'(gnt), 32'b0001);
        repeat (7) begin
            cycle();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(data_out), 32'h3C);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-HOLD, then priority restarts from 0
        out_ready = 1'b0;
        req = 4'b0010;
        req_data[1*DW +: DW] = 8'h77;
        cycle();
        chk("pre_rst_data", 32'(data_out), 32'h77);
        req = 4'b0100;
        req_data[2*DW +: DW] = 8'h5A;
        out_ready = 1'b1;
        do_reset();
        cap_log.delete();
        repeat (3) cycle();
        chk("post_rst_first", (cap_log.size() > 0) ? 32'(cap_log[0]) : 32'hFFFF_FFFF, 32'd2);

        // Randomized traffic with mixed persistent requesters
        rand_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            persist = NR'($urandom);
            repeat (500) cycle();
        end
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
